// File: rtl/dmem_load_unit_pkg.sv
// Shared types and constants for the data-memory load unit.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic MW_BYTE = 1'b0;
    localparam logic MW_WORD = 1'b1;

    // Big-endian lanes: byte address 0 lives in the top byte of the word.
    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_LSB = 0;

endpackage

// File: rtl/dmem_load_unit_if.sv
// Request, memory and response channels of the load unit.
interface dmem_load_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_memwidth;
    logic              req_signed;
    logic              mem_re;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    modport slave (
        input  req_valid, req_addr, req_memwidth, req_signed,
        input  mem_rdata, mem_rvalid, resp_ready,
        output req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_err
    );

    modport master (
        output req_valid, req_addr, req_memwidth, req_signed,
        output mem_rdata, mem_rvalid, resp_ready,
        input  req_ready, mem_re, mem_addr, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/dmem_load_unit_load_extract.sv
// Byte-lane select with sign/zero extension, or word pass-through.
module load_extract
    import dmem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_lane,
    input  logic        i_memwidth,
    input  logic        i_signed,
    output logic [31:0] o_data
);
    logic [7:0] w_byte;

    always_comb begin
        w_byte = i_rdata[LANE0_LSB +: 8];
        case (i_lane)
            2'd0: w_byte = i_rdata[LANE0_LSB +: 8];
            2'd1: w_byte = i_rdata[LANE1_LSB +: 8];
            2'd2: w_byte = i_rdata[LANE2_LSB +: 8];
            2'd3: w_byte = i_rdata[LANE3_LSB +: 8];
            default: w_byte = i_rdata[LANE0_LSB +: 8];
        endcase
    end

    always_comb begin
        if (i_memwidth == MW_WORD)
            o_data = i_rdata;
        else
            o_data = {{24{i_signed & w_byte[7]}}, w_byte};
    end
endmodule

// File: rtl/dmem_load_unit.sv
// Load unit: issues a word read, waits with timeout, returns the extended byte/word.
// Optional: define DMEM_MISALIGN_ERR_EN to reject unaligned word loads without a memory read.
module dmem_load_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    dmem_load_unit_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-3:0] r_word;
    logic [1:0]        r_lane;
    logic              r_memwidth;
    logic              r_signed;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_resp_data;
    logic              r_resp_err;
    logic [31:0]       w_ext;
    logic              w_timeout;
    logic              w_misalign;

`ifdef DMEM_MISALIGN_ERR_EN
    assign w_misalign = (bus.req_memwidth == MW_WORD) && (bus.req_addr[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    load_extract u_extract (
        .i_rdata    (bus.mem_rdata),
        .i_lane     (r_lane),
        .i_memwidth (r_memwidth),
        .i_signed   (r_signed),
        .o_data     (w_ext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        bus.req_ready  = 1'b0;
        bus.mem_re     = 1'b0;
        bus.resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    w_state_nxt = w_misalign ? ST_RESP : ST_MEM;
            end
            ST_MEM: begin
                bus.mem_re = 1'b1;
                if (bus.mem_rvalid || w_timeout)
                    w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, timeout counter and response capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word      <= '0;
            r_lane      <= 2'b00;
            r_memwidth  <= MW_BYTE;
            r_signed    <= 1'b0;
            r_cnt       <= '0;
            r_resp_data <= 32'h0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_word     <= bus.req_addr[ADDR_W-1:2];
                        r_lane     <= bus.req_addr[1:0];
                        r_memwidth <= bus.req_memwidth;
                        r_signed   <= bus.req_signed;
                        r_cnt      <= '0;
                        if (w_misalign) begin
                            r_resp_data <= 32'h0;
                            r_resp_err  <= 1'b1;
                        end
                    end
                end
                ST_MEM: begin
                    // A response arriving on the last allowed cycle beats the timeout.
                    if (bus.mem_rvalid) begin
                        r_resp_data <= w_ext;
                        r_resp_err  <= 1'b0;
                    end else if (w_timeout) begin
                        r_resp_data <= 32'h0;
                        r_resp_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr  = r_word;
    assign bus.resp_data = r_resp_data;
    assign bus.resp_err  = r_resp_err;
endmodule

// File: tb/tb_dmem_load_unit.sv
// Directed table-driven bench for dmem_load_unit (TIMEOUT=16, ADDR_W=32).
module tb_dmem_load_unit;
    localparam int NEVER = 1000;

    typedef struct {
        logic [31:0] addr;
        logic        mw;
        logic        sg;
        logic [31:0] rdata;
        int          delay;
        int          hold;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [31:0] exp_maddr;
        int          exp_memre;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    dmem_load_unit_if #(.ADDR_W(32)) bus ();

    dmem_load_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int lat;
        int nre;
        int k;
        bus.req_addr     = v.addr;
        bus.req_memwidth = v.mw;
        bus.req_signed   = v.sg;
        bus.req_valid    = 1'b1;
        chk({nm, ".req_ready_idle"}, {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 0;
        nre = 0;
        k   = 0;
        while (!bus.resp_valid && lat < 40) begin
            if (bus.mem_re) nre++;
            if (k == 0) chk({nm, ".mem_addr"}, {2'b0, bus.mem_addr}, v.exp_maddr);
            bus.mem_rvalid = (k == v.delay);
            bus.mem_rdata  = (k == v.delay) ? v.rdata : 32'h5A5A5A5A;
            @(posedge clk); #1;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = 32'h0;
            k++;
            lat++;
        end
        chk({nm, ".resp_valid"}, {31'b0, bus.resp_valid}, 32'd1);
        chk({nm, ".latency"}, lat, v.exp_lat);
        chk({nm, ".mem_re_cycles"}, nre, v.exp_memre);
        chk({nm, ".resp_data"}, bus.resp_data, v.exp_data);
        chk({nm, ".resp_err"}, {31'b0, bus.resp_err}, {31'b0, v.exp_err});
        for (int h = 0; h < v.hold; h++) begin
            bus.req_valid = 1'b1;
            @(posedge clk); #1;
            chk({nm, ".hold_data"}, bus.resp_data, v.exp_data);
            chk({nm, ".hold_valid"}, {31'b0, bus.resp_valid}, 32'd1);
            chk({nm, ".hold_req_ready"}, {31'b0, bus.req_ready}, 32'd0);
            chk({nm, ".hold_mem_re"}, {31'b0, bus.mem_re}, 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk({nm, ".released"}, {31'b0, bus.resp_valid}, 32'd0);
        chk({nm, ".req_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
        chk({nm, ".data_retained"}, bus.resp_data, v.exp_data);
    endtask

    vec_t vecs[10];
    vec_t extra;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_memwidth = 1'b0;
        bus.req_signed   = 1'b0;
        bus.mem_rdata    = 32'h0;
        bus.mem_rvalid   = 1'b0;
        bus.resp_ready   = 1'b0;

        //            addr          mw    sg    rdata          dly    hold exp_data       err   maddr  memre lat
        vecs[0] = '{32'h00000011, 1'b0, 1'b1, 32'h12A45678, 0,     0, 32'hFFFFFFA4, 1'b0, 32'h4,  1,  1};
        vecs[1] = '{32'h00000011, 1'b0, 1'b0, 32'h12A45678, 0,     0, 32'h000000A4, 1'b0, 32'h4,  1,  1};
        vecs[2] = '{32'h00000000, 1'b0, 1'b0, 32'h80FF0001, 0,     0, 32'h00000080, 1'b0, 32'h0,  1,  1};
        vecs[3] = '{32'h00000003, 1'b0, 1'b0, 32'h80FF0001, 1,     0, 32'h00000001, 1'b0, 32'h0,  2,  2};
        vecs[4] = '{32'h00000000, 1'b0, 1'b1, 32'h80FF0001, 0,     0, 32'hFFFFFF80, 1'b0, 32'h0,  1,  1};
        vecs[5] = '{32'h00000105, 1'b0, 1'b1, 32'h80FF0001, 0,     0, 32'hFFFFFFFF, 1'b0, 32'h41, 1,  1};
        vecs[6] = '{32'h00000008, 1'b1, 1'b1, 32'hDEADBEEF, 2,     4, 32'hDEADBEEF, 1'b0, 32'h2,  3,  3};
        vecs[7] = '{32'h00000010, 1'b1, 1'b0, 32'h11111111, NEVER, 0, 32'h00000000, 1'b1, 32'h4,  16, 16};
        vecs[8] = '{32'h00000013, 1'b0, 1'b1, 32'h12A45678, 15,    0, 32'h00000078, 1'b0, 32'h4,  16, 16};
`ifdef DMEM_MISALIGN_ERR_EN
        vecs[9] = '{32'h00000006, 1'b1, 1'b0, 32'hCAFEF00D, 0,     0, 32'h00000000, 1'b1, 32'h1,  0,  0};
`else
        vecs[9] = '{32'h00000006, 1'b1, 1'b0, 32'hCAFEF00D, 0,     0, 32'hCAFEF00D, 1'b0, 32'h1,  1,  1};
`endif

        #1;
        chk("rst.req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst.mem_re", {31'b0, bus.mem_re}, 32'd0);
        chk("rst.mem_addr", {2'b0, bus.mem_addr}, 32'd0);
        chk("rst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("rst.resp_data", bus.resp_data, 32'd0);
        chk("rst.resp_err", {31'b0, bus.resp_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Stray memory response while idle must be ignored.
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        chk("idle_rvalid.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("idle_rvalid.req_ready", {31'b0, bus.req_ready}, 32'd1);

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        extra = '{32'h00000020, 1'b1, 1'b0, 32'h13572468, 0, 0, 32'h13572468, 1'b0, 32'h8, 1, 1};
        run_vec(extra, "pre_reset_lw");

        // Asynchronous reset in the middle of a memory wait.
        bus.req_addr     = 32'h00000044;
        bus.req_memwidth = 1'b1;
        bus.req_valid    = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("midrst.in_mem", {31'b0, bus.mem_re}, 32'd1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        chk("midrst.mem_re", {31'b0, bus.mem_re}, 32'd0);
        chk("midrst.mem_addr", {2'b0, bus.mem_addr}, 32'd0);
        chk("midrst.resp_data", bus.resp_data, 32'd0);
        chk("midrst.resp_valid", {31'b0, bus.resp_valid}, 32'd0);
        chk("midrst.req_ready", {31'b0, bus.req_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("postrst.req_ready", {31'b0, bus.req_ready}, 32'd1);
        chk("postrst.mem_re", {31'b0, bus.mem_re}, 32'd0);

        extra = '{32'h00000024, 1'b1, 1'b1, 32'h0BADF00D, 1, 0, 32'h0BADF00D, 1'b0, 32'h9, 2, 2};
        run_vec(extra, "post_reset_lw");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
